// File: rtl/bias_sched_pkg.sv
// Shared types and constants for the bias group scheduler: lane geometry,
// saturation bounds, FSM state encoding and a lane-slice helper.
package bias_sched_pkg;

  localparam int N_adder_tree = 16;
  localparam int DW           = 18;
  localparam int BEAT_W       = N_adder_tree * DW;

  // Signed DW-bit clamp bounds: +2^(DW-1)-1 and -2^(DW-1)
  localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef logic [BEAT_W-1:0] beat_t;

  // Lane idx of a packed beat; lane 0 sits in the least significant bits
  function automatic logic [DW-1:0] lane_slice(input beat_t beat, input int unsigned idx);
    return beat[idx*DW +: DW];
  endfunction

endpackage

// File: rtl/bias_lane_add_sat.sv
// One lane of the bias adder: signed DW-bit accumulator + bias, computed at
// DW+1 bits and clamped back to DW bits. With BIAS_RELU_EN defined the clamped
// value is additionally floored at zero. Purely combinational.
module bias_lane_add_sat
  import bias_sched_pkg::*;
(
  input  logic [DW-1:0] i_acc,
  input  logic [DW-1:0] i_bias,
  output logic [DW-1:0] o_sum
);

  logic [DW:0]   w_wide;
  logic [DW-1:0] w_sat;

  // Sign-extend both operands so the extra bit holds the true sign of the sum
  assign w_wide = {i_acc[DW-1], i_acc} + {i_bias[DW-1], i_bias};

  // Clamp when the top two bits disagree, i.e. the DW-bit result would wrap
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves w_sat unassigned (no latch).
    w_sat = w_wide[DW-1:0];
    if (w_wide[DW] != w_wide[DW-1]) begin
      w_sat = w_wide[DW] ? SAT_MIN : SAT_MAX;
    end
  end

`ifdef BIAS_RELU_EN
  assign o_sum = w_sat[DW-1] ? '0 : w_sat;
`else
  assign o_sum = w_sat;
`endif

endmodule

// File: rtl/bias_group_scheduler.sv
// Bias group scheduler: walks PIX_PER_GROUP beats of each of N_GROUPS channel
// groups, adding that group's constant bias bank to every 16-lane accumulator
// beat, and presents the result through a single output register stage.
// Optional macro BIAS_RELU_EN applies a ReLU to every lane after saturation.
module bias_group_scheduler
  import bias_sched_pkg::*;
#(
  parameter int N_GROUPS      = 3,
  parameter int PIX_PER_GROUP = 196
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [N_GROUPS*BEAT_W-1:0]   bias_bank,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [BEAT_W-1:0]            in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BEAT_W-1:0]            out_data,
  output logic [$clog2(N_GROUPS)-1:0]  out_group,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done
);

  localparam int GW = $clog2(N_GROUPS);
  localparam int PW = (PIX_PER_GROUP > 1) ? $clog2(PIX_PER_GROUP) : 1;

  localparam logic [PW-1:0] PIX_LAST = PW'(PIX_PER_GROUP - 1);
  localparam logic [GW-1:0] GRP_LAST = GW'(N_GROUPS - 1);

  state_t          r_state;
  state_t          w_next_state;
  logic [PW-1:0]   r_pix_cnt;
  logic [GW-1:0]   r_grp_cnt;

  logic            r_out_valid;
  logic [BEAT_W-1:0] r_out_data;
  logic [GW-1:0]   r_out_group;
  logic            r_out_last;
  logic            r_done;

  logic            w_in_fire;
  logic            w_out_fire;
  logic            w_last_beat;
  logic            w_pix_wrap;
  logic [BEAT_W-1:0] w_bank_sel;
  logic [BEAT_W-1:0] w_sum;

  assign w_in_fire   = in_valid && in_ready;
  assign w_out_fire  = r_out_valid && out_ready;
  assign w_pix_wrap  = (r_pix_cnt == PIX_LAST);
  assign w_last_beat = w_pix_wrap && (r_grp_cnt == GRP_LAST);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state: start only counts in IDLE, so a start during DRAIN is dropped
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (start)                    w_next_state = RUN;
      RUN:     if (w_in_fire && w_last_beat) w_next_state = DRAIN;
      DRAIN:   if (w_out_fire)               w_next_state = IDLE;
      default:                               w_next_state = IDLE;
    endcase
  end

  // FSM outputs: accept only while running and the output slot is free or leaving
  always_comb begin
    in_ready = (r_state == RUN) && (!r_out_valid || out_ready);
    busy     = (r_state != IDLE);
  end

  // Pixel / group position of the next beat to be accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_cnt <= '0;
      r_grp_cnt <= '0;
    end else if ((r_state == IDLE) && start) begin
      r_pix_cnt <= '0;
      r_grp_cnt <= '0;
    end else if (w_in_fire) begin
      if (w_pix_wrap) begin
        r_pix_cnt <= '0;
        r_grp_cnt <= (r_grp_cnt == GRP_LAST) ? '0 : r_grp_cnt + 1'b1;
      end else begin
        r_pix_cnt <= r_pix_cnt + 1'b1;
      end
    end
  end

  // Pick the bias bank of the current group (bank is static, no register)
  always_comb begin
    w_bank_sel = '0;
    for (int g = 0; g < N_GROUPS; g++) begin
      if (r_grp_cnt == GW'(g)) begin
        w_bank_sel = bias_bank[g*BEAT_W +: BEAT_W];
      end
    end
  end

  for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
    bias_lane_add_sat u_lane (
      .i_acc  (lane_slice(in_data, i)),
      .i_bias (lane_slice(w_bank_sel, i)),
      .o_sum  (w_sum[i*DW +: DW])
    );
  end

  // Output register: reload on accept (even while draining), else empty on downstream accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_group <= '0;
      r_out_last  <= 1'b0;
    end else if (w_in_fire) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sum;
      r_out_group <= r_grp_cnt;
      r_out_last  <= w_last_beat;
    end else if (w_out_fire) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  // Completion pulse: the cycle after the final beat leaves downstream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == DRAIN) && w_out_fire;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_group = r_out_group;
  assign out_last  = r_out_last;
  assign done      = r_done;

endmodule
